// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide data memory port.
// Sub-word stores are read-modify-write; loads are lane-selected and extended.
module dmem_lsu #(
  parameter int unsigned DMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StIssue, StCapture, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        fault_q, fault_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        req_fault;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = (state_q == StIdle) && req_valid;

  always_comb begin
    req_fault = (req_size == 2'b11) ||
                ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                ({2'b00, req_addr[31:2]} >= DMEM_WORDS);
  end

  // Lane extraction and merge both work on the word returned in CAPTURE.
  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_fault) begin
            state_d = StResp;
          end else if (req_write && (req_size == 2'b10)) begin
            state_d = StWrite;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue:   state_d = StCapture;
      StCapture: state_d = write_q ? StWrite : StResp;
      StWrite:   state_d = StResp;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    write_d     = write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    fault_d     = fault_q;
    addr_d      = addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if (accept) begin
      write_d     = req_write;
      size_d      = req_size;
      uns_d       = req_unsigned;
      lane_d      = req_addr[1:0];
      wdata_d     = req_wdata[15:0];
      fault_d     = req_fault;
      addr_d      = {2'b00, req_addr[31:2]};
      // Word stores go straight to WRITE, so the full word is staged here.
      mem_wdata_d = req_wdata;
      rdata_d     = 32'h0;
    end else if (state_q == StCapture) begin
      if (write_q) begin
        mem_wdata_d = merged;
      end else begin
        rdata_d = load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0;
      fault_q     <= 1'b0;
      addr_q      <= 32'h0;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      fault_q     <= fault_d;
      addr_q      <= addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Gating with rst keeps a reset cycle from committing a write or a response.
  assign req_ready = (state_q == StIdle) && !rst;
  assign rsp_valid = (state_q == StResp) && !rst;
  assign rsp_fault = rsp_valid && fault_q;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_write = (state_q == StWrite) && !rst;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vector table, reset corner cases,
// and random accesses checked against an arithmetic reference model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        mem_init;

  logic [31:0] last_waddr;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  dmem_lsu #(.DMEM_WORDS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Data memory: one-cycle read latency, write commits on the clock edge.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_write && (mem_addr < 32)) mem[mem_addr[4:0]] <= mem_wdata;
      mem_rdata <= (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;
    end
  end

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: spec rules expressed as plain arithmetic on a word array.
  task automatic ref_access(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic flt,
                            output int lat, output int nwr);
    int unsigned idx, off, nb;
    logic [31:0] mask, val;
    idx = a >> 2;
    off = a % 4;
    flt = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && off != 0) || idx >= 32;
    rd  = 32'h0;
    nwr = 0;
    lat = 1;
    if (!flt) begin
      nb   = 1 << sz;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
      if (w) begin
        ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        nwr = 1;
        lat = (nb == 4) ? 2 : 4;
      end else begin
        val = (ref_mem[idx] >> (8 * off)) & mask;
        if (!u && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
        rd  = val;
        lat = 3;
      end
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic flt,
                        output int nwr);
    int waited;
    lat = 0;
    rd  = 32'h0;
    flt = 1'b0;
    nwr = 0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout: got 0 expected 1");
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (mem_write) begin
          nwr++;
          last_waddr = mem_addr;
          last_wdata = mem_wdata;
        end
        if (rsp_valid) begin
          lat = c;
          rd  = rsp_rdata;
          flt = rsp_fault;
          break;
        end
      end
    end
  endtask

  initial begin
    int          lat, nwr, elat, enwr, seen;
    logic [31:0] rd, erd, a, wd;
    logic        flt, eflt, w, u;
    logic [1:0]  sz;

    rst          = 1'b1;
    mem_init     = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    last_waddr   = 32'h0;
    last_wdata   = 32'h0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;

    //           w     sz     u     addr   wdata          rdata          flt  lat wr
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,         1'b0, 2, 1};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF,  1'b0, 3, 0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, 32'h0,         1'b0, 4, 1};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'hFFFFFFAB,  1'b0, 3, 0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        32'h000000AB,  1'b0, 3, 0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 32'h0,         1'b0, 4, 1};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'h00001234,  1'b0, 3, 0};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'hFFFFABEF,  1'b0, 3, 0};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h0000ABEF,  1'b0, 3, 0};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0,        32'h0,         1'b1, 1, 0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h11, 32'h00007777, 32'h0,         1'b1, 1, 0};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        32'h0,         1'b1, 1, 0};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h80, 32'h12345678, 32'h0,         1'b1, 1, 0};

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    chk("ready_during_reset", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_fault", {31'h0, rsp_fault}, 32'h0);
    chk("reset_mem_write", {31'h0, mem_write}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      access(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr, tbl[i].wdata, lat, rd, flt, nwr);
      ref_access(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr, tbl[i].wdata, erd, eflt, elat, enwr);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_fault", i), {31'h0, flt}, {31'h0, tbl[i].exp_fault});
      chk($sformatf("vec%0d_writes", i), nwr, tbl[i].exp_wr);
      if (i == 0) begin
        chk("sw_mem_addr", last_waddr, 32'h4);
        chk("sw_mem_wdata", last_wdata, 32'hDEADBEEF);
      end
      if (i == 2) chk("sb_word4", mem[4], 32'hDEADABEF);
      if (i == 5) chk("sh_word4", mem[4], 32'h1234ABEF);
    end

    // Reset pulsed during the WRITE cycle of a byte store.
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h10;
    req_wdata    = 32'h55;
    chk("rstw_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    if (rsp_valid) seen++;
    chk("rstw_mem_write", {31'h0, mem_write}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready_after", {31'h0, req_ready}, 32'h1);
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("rstw_no_rsp", seen, 0);
    chk("rstw_word4", mem[4], ref_mem[4]);

    // Random accesses against the reference model.
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 36 * 4 - 1);
      if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
      wd = $urandom;
      access(w, sz, u, a, wd, lat, rd, flt, nwr);
      ref_access(w, sz, u, a, wd, erd, eflt, elat, enwr);
      chk($sformatf("rnd%0d_latency", n), lat, elat);
      chk($sformatf("rnd%0d_rdata", n), rd, erd);
      chk($sformatf("rnd%0d_fault", n), {31'h0, flt}, {31'h0, eflt});
      chk($sformatf("rnd%0d_writes", n), nwr, enwr);
      if (w && !eflt) chk($sformatf("rnd%0d_word", n), mem[a[6:2]], ref_mem[a[6:2]]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
